register_file: RTL and testbench

General-purpose register file for the decode stage: 32 registers of 32 bits, two combinational read ports and one write port. The decode stage drives the read addresses from instruction rs/rt, and the writeback stage drives the write port. Register 0 is hard-wired to zero, so no write-enable signal is needed: writeback of "nothing" is encoded as a write to register 0.

---
 rtl/register_file.sv | 94 +++++++++
 tb/tb_register_file.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// General-purpose register file for the decode stage: 32 x 32-bit registers,
// two combinational read ports and one synchronous write port. Register 0 is
// hard-wired to zero and is not stored, so writeback of "nothing" is encoded
// as a write to address 0.
//
// Ports
//   clk         in   1   system clock, all state updates on rising edge
//   rst         in   1   synchronous active-low reset (clears r1..r31)
//   read1_addr  in   5   read port 1 address (instruction rs)
//   read2_addr  in   5   read port 2 address (instruction rt)
//   write_addr  in   5   write address, 0 means no write
//   data_in     in   32  write data
//   data_out1   out  32  contents of read1_addr (combinational, forwarded)
//   data_out2   out  32  contents of read2_addr (combinational, forwarded)
// ---------------------------------------------------------------------------
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  read1_addr,
    input  logic [4:0]  read2_addr,
    input  logic [4:0]  write_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out1,
    output logic [31:0] data_out2
);

    localparam int unsigned REGADDR_WIDTH = 5;
    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned NUM_REGS      = 32;

    // Physical storage for r1..r31 only; r0 is a constant zero.
    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

    logic                  write_en;
    logic [DATA_WIDTH-1:0] rd1_stored;
    logic [DATA_WIDTH-1:0] rd2_stored;
    logic                  fwd1;
    logic                  fwd2;

    // A real write only happens out of reset and to a non-zero address.
    assign write_en = rst && (write_addr != '0);

    // Next-state: reset clears everything and overrides any pending write.
    always_comb begin
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (!rst) begin
                regs_d[i] = '0;
            end else if (write_addr == REGADDR_WIDTH'(i)) begin
                regs_d[i] = data_in;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    // Stored-value read muxes; address 0 falls through to zero.
    always_comb begin
        rd1_stored = '0;
        rd2_stored = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (read1_addr == REGADDR_WIDTH'(i)) begin
                rd1_stored = regs_q[i];
            end
            if (read2_addr == REGADDR_WIDTH'(i)) begin
                rd2_stored = regs_q[i];
            end
        end
    end

    // Write-through forwarding so decode sees the value being written back
    // on the same edge that commits it.
    assign fwd1 = write_en && (read1_addr == write_addr);
    assign fwd2 = write_en && (read2_addr == write_addr);

    // Output select: reset forces zero, then forwarding, then storage.
    always_comb begin
        data_out1 = '0;
        data_out2 = '0;
        if (rst) begin
            data_out1 = fwd1 ? data_in : rd1_stored;
            data_out2 = fwd2 ? data_in : rd2_stored;
        end
    end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  read1_addr;
    logic [4:0]  read2_addr;
    logic [4:0]  write_addr;
    logic [31:0] data_in;
    logic [31:0] data_out1;
    logic [31:0] data_out2;

    logic [31:0] model [32];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    register_file dut (
        .clk        (clk),
        .rst        (rst),
        .read1_addr (read1_addr),
        .read2_addr (read2_addr),
        .write_addr (write_addr),
        .data_in    (data_in),
        .data_out1  (data_out1),
        .data_out2  (data_out2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: what a reader should see given current inputs and model.
    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (!rst)                               return 32'h0;
        if (a == 5'd0)                          return 32'h0;
        if (write_addr != 5'd0 && a == write_addr) return data_in;
        return model[a];
    endfunction

    // Present inputs mid-cycle and let combinational outputs settle.
    task automatic drive(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] wa, input logic [31:0] d);
        @(negedge clk);
        rst        = r;
        read1_addr = a1;
        read2_addr = a2;
        write_addr = wa;
        data_in    = d;
        #1;
    endtask

    // Advance through the rising edge and update the model.
    task automatic commit();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (write_addr != 5'd0) begin
            model[write_addr] = data_in;
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        drive(1'b1, 5'd0, 5'd0, a, d);
        commit();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst = 1'b0; read1_addr = '0; read2_addr = '0; write_addr = '0; data_in = '0;

        // Reset held for two cycles, outputs forced to zero while low.
        drive(1'b0, 5'd3, 5'd9, 5'd7, 32'hFFFF_FFFF);
        check_eq("rst_low_out1", data_out1, 32'h0);
        check_eq("rst_low_out2", data_out2, 32'h0);
        commit();
        drive(1'b0, 5'd31, 5'd1, 5'd1, 32'h1234_5678);
        commit();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'(i), 5'(31 - i), 5'd0, $urandom);
            check_eq("post_rst_out1", data_out1, 32'h0);
            check_eq("post_rst_out2", data_out2, 32'h0);
            commit();
        end

        // Write then read, neighbours untouched.
        write_reg(5'd5, 32'hDEAD_BEEF);
        drive(1'b1, 5'd5, 5'd5, 5'd0, 32'h0);
        check_eq("wr_rd_out1", data_out1, 32'hDEAD_BEEF);
        check_eq("wr_rd_out2", data_out2, 32'hDEAD_BEEF);
        commit();
        drive(1'b1, 5'd4, 5'd6, 5'd0, 32'h0);
        check_eq("nbr4", data_out1, 32'h0);
        check_eq("nbr6", data_out2, 32'h0);
        commit();

        // r0 cannot be written and is never forwarded.
        drive(1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF);
        check_eq("r0_nofwd", data_out1, 32'h0);
        commit();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 32'h0);
        check_eq("r0_after", data_out1, 32'h0);
        commit();

        // Forwarding on both ports, then the committed value.
        write_reg(5'd7, 32'h1111_1111);
        drive(1'b1, 5'd7, 5'd7, 5'd7, 32'h2222_2222);
        check_eq("fwd_out1", data_out1, 32'h2222_2222);
        check_eq("fwd_out2", data_out2, 32'h2222_2222);
        commit();
        drive(1'b1, 5'd7, 5'd7, 5'd0, 32'h0);
        check_eq("fwd_commit1", data_out1, 32'h2222_2222);
        check_eq("fwd_commit2", data_out2, 32'h2222_2222);
        commit();

        // Independent ports, boundary registers r1 and r31.
        write_reg(5'd1, 32'h0000_0001);
        write_reg(5'd31, 32'h8000_0000);
        drive(1'b1, 5'd1, 5'd31, 5'd0, 32'h0);
        check_eq("ind_out1", data_out1, 32'h0000_0001);
        check_eq("ind_out2", data_out2, 32'h8000_0000);
        commit();
        drive(1'b1, 5'd31, 5'd1, 5'd0, 32'h0);
        check_eq("swap_out1", data_out1, 32'h8000_0000);
        check_eq("swap_out2", data_out2, 32'h0000_0001);
        commit();

        // Reset mid-operation beats a concurrent write.
        write_reg(5'd3, 32'hA5A5_A5A5);
        drive(1'b1, 5'd3, 5'd3, 5'd0, 32'h0);
        check_eq("pre_rst_r3", data_out1, 32'hA5A5_A5A5);
        commit();
        drive(1'b0, 5'd3, 5'd3, 5'd3, 32'h5A5A_5A5A);
        check_eq("mid_rst_out1", data_out1, 32'h0);
        check_eq("mid_rst_out2", data_out2, 32'h0);
        commit();
        drive(1'b1, 5'd3, 5'd7, 5'd0, 32'h0);
        check_eq("post_rst_r3", data_out1, 32'h0);
        check_eq("post_rst_r7", data_out2, 32'h0);
        commit();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic        r;
            logic [4:0]  wa, a1, a2;
            r  = ($urandom_range(0, 24) != 0);
            wa = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            drive(r, a1, a2, wa, $urandom);
            check_eq("rand_out1", data_out1, ref_read(read1_addr));
            check_eq("rand_out2", data_out2, ref_read(read2_addr));
            commit();
        end

        // Final sweep of all stored registers.
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'(i), 5'(i), 5'd0, 32'h0);
            check_eq("sweep_out1", data_out1, model[i]);
            check_eq("sweep_out2", data_out2, (i == 0) ? 32'h0 : model[i]);
            commit();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
